sine_dds_ctrl: RTL and testbench
================================

// Module: sine_dds_ctrl
// PURPOSE
//  Phase-accumulator sequencer (DDS controller) for the combinational sine ROM.
//  Drives the ROM address from a modular phase accumulator and registers each returned
//  sample into a valid/ready output stream.
//  Supports bursts of N samples or continuous streaming, plus a clean stop.
//  Sits between the register/control layer and downstream signal-processing blocks.
// PARAMETERS
//  PHASE_WIDTH  32  accumulator width; wraps modulo 2^PHASE_WIDTH
//  ADDR_WIDTH   8   ROM address width; address = top ADDR_WIDTH bits of phase
//  DATA_WIDTH   16  signed sample width (Q12 samples from ROM)
//  COUNT_WIDTH  16  width of burst length
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous, active-high reset
//  start        in   1            begin burst; sampled only in IDLE
//  stop         in   1            request abort; sampled only in RUN
//  tune_word    in   PHASE_WIDTH  phase increment per sample; latched on start
//  phase_offset in   PHASE_WIDTH  phase offset added to accumulator; latched on start
//  num_samples  in   COUNT_WIDTH  burst length; 0 = continuous; latched on start
//  lut_addr     out  ADDR_WIDTH   ROM address (combinational)
//  lut_sample   in   DATA_WIDTH   signed ROM data, combinational from lut_addr
//  m_valid      out  1            output sample valid
//  m_ready      in   1            downstream accept
//  m_data       out  DATA_WIDTH   signed output sample (registered)
//  busy         out  1            high in RUN
//  done         out  1            one-cycle pulse when burst ends or stop completes
// BEHAVIOUR
//  Reset values: m_valid=0, m_data=0, busy=0, done=0, state=IDLE, acc=0, counters=0.
//  Internal regs: acc (PHASE_WIDTH), tune_r, offset_r, remaining (COUNT_WIDTH), cont_r, stop_pend.
//  Address generation:
//   - IDLE: lut_addr = phase_offset[PW-1 -: AW].
//   - RUN:  lut_addr = (acc + offset_r)[PW-1 -: AW]. Sum is modulo 2^PW; carry is dropped.
//  FSM states: IDLE, RUN.
//  IDLE & start:
//   - m_data <= lut_sample, m_valid <= 1.
//   - acc <= tune_word.
//   - tune_r, offset_r <= inputs.
//   - remaining <= num_samples; cont_r <= (num_samples == 0).
//   - stop_pend <= 0; go to RUN.
//   - Latency: first sample valid the cycle after start.
//  Special case, start with num_samples = 1: enter RUN anyway. Burst ends on the first handshake.
//  RUN, handshake (m_valid & m_ready):
//   - If stop_pend | stop | (!cont_r & remaining == 1): m_valid <= 0, done <= 1, go to IDLE.
//   - Otherwise: m_data <= lut_sample, acc <= acc + tune_r.
//   - In both cases, when !cont_r: remaining <= remaining - 1.
//  RUN, no handshake:
//   - m_data and m_valid are held stable (AXI-style: valid never drops without acceptance).
//   - stop sets stop_pend.
//  Throughput: one sample per cycle while m_ready is held high. No bubbles.
//  start in RUN is ignored. stop in IDLE is ignored.
//  Simultaneous stop and handshake: the accepted sample is the last one and the block ends that cycle.
//  busy = (state == RUN). done is high for exactly one cycle, the cycle after the final handshake.
//  tune_word = 0 is legal: the same sample repeats.
//  Accumulator wrap is silent and continuous.
//  rst mid-burst: everything returns to reset values on the next edge. No done pulse.
// TESTING
//  1. tune=2^24, off=0, N=4, m_ready=1
//     -> lut_addr 0,1,2,3; m_data=rom[0..3] on consecutive cycles; done one cycle after 4th accept.
//  2. Same as test 1 with m_ready low for 3 cycles on sample 2
//     -> m_data holds rom[1]; m_valid stays 1; no sample skipped.
//  3. N=0, tune=2^31, off=2^30 -> alternating rom[64], rom[192] indefinitely.
//     Assert stop -> ends after the next accept, done pulses.
//  4. tune=0xFF000000, N=3 -> addresses 0, 255, 254 (wrap-around).
//     Check busy=1 for the whole burst and 0 after done.
//  5. Assert rst during a continuous run -> next cycle m_valid=0, busy=0, done=0.
//     A subsequent start runs normally.
//  6. N=1 with stop and start together in IDLE -> exactly one sample, then done; stop ignored.

Source files
------------

// File: rtl/sine_dds_if.sv
// Control, ROM lookup and sample-stream signals of the sine DDS sequencer.
// The sequencer takes the master side. The controlling block, the ROM and the sink take the slave side.
interface sine_dds_if #(
   parameter int PHASE_WIDTH = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 16
);
   logic                          start;
   logic                          stop;
   logic [PHASE_WIDTH-1:0]        tune_word;
   logic [PHASE_WIDTH-1:0]        phase_offset;
   logic [COUNT_WIDTH-1:0]        num_samples;
   logic [ADDR_WIDTH-1:0]         lut_addr;
   logic signed [DATA_WIDTH-1:0]  lut_sample;
   logic                          m_valid;
   logic                          m_ready;
   logic signed [DATA_WIDTH-1:0]  m_data;
   logic                          busy;
   logic                          done;

   modport master (
      input  start, stop, tune_word, phase_offset, num_samples, lut_sample, m_ready,
      output lut_addr, m_valid, m_data, busy, done
   );

   modport slave (
      output start, stop, tune_word, phase_offset, num_samples, lut_sample, m_ready,
      input  lut_addr, m_valid, m_data, busy, done
   );
endinterface

// File: rtl/sine_dds_ctrl.sv
// Phase-accumulator sequencer for a combinational sine ROM. It sends ROM samples into a valid/ready stream.
//   state | meaning
//   IDLE  | waiting for start; ROM address follows phase_offset
//   RUN   | streaming; lut_addr points at the sample after the one on m_data
module sine_dds_ctrl #(
   parameter int PHASE_WIDTH = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   sine_dds_if.master bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                        state_q, state_d;
   logic [PHASE_WIDTH-1:0]        acc_q, acc_d;
   logic [PHASE_WIDTH-1:0]        tune_q, tune_d;
   logic [PHASE_WIDTH-1:0]        offset_q, offset_d;
   logic [COUNT_WIDTH-1:0]        remaining_q, remaining_d;
   logic                          cont_q, cont_d;
   logic                          stop_pend_q, stop_pend_d;
   logic                          m_valid_q, m_valid_d;
   logic signed [DATA_WIDTH-1:0]  m_data_q, m_data_d;
   logic                          done_q, done_d;
   logic [PHASE_WIDTH-1:0]        phase_sel;
   logic                          handshake;
   logic                          last_hs;

   // Sum wraps modulo 2^PHASE_WIDTH; only the top bits form the ROM address.
   assign phase_sel = (state_q == RUN) ? (acc_q + offset_q) : bus.phase_offset;
   assign handshake = m_valid_q & bus.m_ready;

   assign bus.lut_addr = ADDR_WIDTH'(phase_sel >> (PHASE_WIDTH - ADDR_WIDTH));
   assign bus.m_valid  = m_valid_q;
   assign bus.m_data   = m_data_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         tune_q      <= '0;
         offset_q    <= '0;
         remaining_q <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         tune_q      <= tune_d;
         offset_q    <= offset_d;
         remaining_q <= remaining_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      tune_d      = tune_q;
      offset_d    = offset_q;
      remaining_d = remaining_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      done_d      = 1'b0;
      last_hs     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               m_data_d    = bus.lut_sample;
               m_valid_d   = 1'b1;
               acc_d       = bus.tune_word;
               tune_d      = bus.tune_word;
               offset_d    = bus.phase_offset;
               remaining_d = bus.num_samples;
               cont_d      = (bus.num_samples == '0);
               stop_pend_d = 1'b0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (handshake) begin
               last_hs = stop_pend_q | bus.stop | (!cont_q && remaining_q == COUNT_WIDTH'(1));
               if (last_hs) begin
                  m_valid_d = 1'b0;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end else begin
                  m_data_d = bus.lut_sample;
                  acc_d    = acc_q + tune_q;
               end
               if (!cont_q) begin
                  remaining_d = remaining_q - COUNT_WIDTH'(1);
               end
            end else if (bus.stop) begin
               // The sample on m_data must still be accepted before the stream can end.
               stop_pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sine_dds_ctrl.sv
// Directed bench for sine_dds_ctrl. A model ROM feeds the DUT. The expected stream goes into a
// scoreboard queue and is compared when samples are handshaken.
module tb_sine_dds_ctrl;
   localparam int PW = 32;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sine_dds_if #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

   sine_dds_ctrl #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic signed [DW-1:0] rom [256];
   assign bus.lut_sample = rom[bus.lut_addr];

   int errors = 0;
   int checks = 0;
   logic signed [DW-1:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Stream monitor: every accepted sample must match the head of the scoreboard.
   // A stalled sample must be held unchanged.
   logic                 stall_q = 1'b0;
   logic signed [DW-1:0] held_q  = '0;
   always @(negedge clk) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         if (stall_q) begin
            check("hold_valid", 32'(bus.m_valid), 32'd1);
            check("hold_data", 32'(bus.m_data), 32'(held_q));
         end
         if (bus.m_valid && bus.m_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL extra_sample: observed data=0x%0h expected no sample", bus.m_data);
            end
            if (sb.size() != 0) check("sample", 32'(bus.m_data), 32'(sb.pop_front()));
         end
         stall_q <= bus.m_valid && !bus.m_ready;
         held_q  <= bus.m_data;
      end
   end

   task automatic push_exp(input logic [PW-1:0] tune, input logic [PW-1:0] off, input int n);
      logic [PW-1:0] ph;
      for (int k = 0; k < n; k++) begin
         ph = off + tune * 32'(k);
         sb.push_back(rom[ph[PW-1 -: AW]]);
      end
   endtask

   task automatic start_burst(input logic [PW-1:0] tune, input logic [PW-1:0] off,
                              input logic [CW-1:0] n, input int pushn);
      bus.tune_word    = tune;
      bus.phase_offset = off;
      bus.num_samples  = n;
      bus.start        = 1'b1;
      push_exp(tune, off, pushn);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      check({tag, "_valid_end"}, 32'(bus.m_valid), 32'd0);
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_sb_one(input string tag, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check({tag, "_reach_last"}, 32'(ok), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'(i * 113 - 9000);
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.stop         = 1'b0;
      bus.m_ready      = 1'b0;
      bus.tune_word    = '0;
      bus.phase_offset = 32'h4000_0000;
      bus.num_samples  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.m_valid), 32'd0);
      check("rst_data", 32'(bus.m_data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_addr", 32'(bus.lut_addr), 32'd64);

      // 1: four-sample burst at full rate
      bus.m_ready = 1'b1;
      start_burst(32'h0100_0000, 32'h0, 16'd4, 4);
      check("t1_addr1", 32'(bus.lut_addr), 32'd1);
      wait_done("t1", 20);

      // 2: stall on the second sample
      start_burst(32'h0100_0000, 32'h0, 16'd4, 4);
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.m_ready = 1'b1;
      wait_done("t2", 20);

      // 3: continuous alternating stream, stop together with an accept
      start_burst(32'h8000_0000, 32'h4000_0000, 16'd0, 6);
      wait_sb_one("t3", 40);
      bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.stop = 1'b0;
      wait_done("t3", 10);

      // 3b: stop while stalled is remembered until the next accept
      start_burst(32'h8000_0000, 32'h4000_0000, 16'd0, 3);
      wait_sb_one("t3b", 40);
      bus.m_ready = 1'b0;
      bus.stop    = 1'b1;
      @(posedge clk); #1;
      bus.stop = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t3b_busy_pend", 32'(bus.busy), 32'd1);
      bus.m_ready = 1'b1;
      wait_done("t3b", 10);

      // 4: negative-going wrap of the phase
      start_burst(32'hFF00_0000, 32'h0, 16'd3, 3);
      check("t4_addr1", 32'(bus.lut_addr), 32'd255);
      wait_done("t4", 20);

      // 5: reset in the middle of a continuous run
      start_burst(32'h0100_0000, 32'h0, 16'd0, 100);
      repeat (5) @(posedge clk);
      #1;
      bus.m_ready = 1'b0;
      rst         = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      check("t5_valid", 32'(bus.m_valid), 32'd0);
      check("t5_busy", 32'(bus.busy), 32'd0);
      check("t5_done", 32'(bus.done), 32'd0);
      check("t5_data", 32'(bus.m_data), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("t5_done_after", 32'(bus.done), 32'd0);
      bus.m_ready = 1'b1;
      start_burst(32'h0100_0000, 32'h0100_0000, 16'd2, 2);
      wait_done("t5", 20);

      // 6: single-sample burst where stop arrives together with start
      bus.stop = 1'b1;
      start_burst(32'h0300_0000, 32'h2000_0000, 16'd1, 1);
      bus.stop = 1'b0;
      wait_done("t6", 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
